// File: rtl/energy_window_monitor.sv
// energy_window_monitor: sliding-window average of DEPTH unsigned samples,
// with a hysteresis threshold comparator on the registered average.
// Optional feature macro: ENERGY_PEAK_HOLD_EN (peak_out tracks the max average).
module energy_window_monitor #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             clear,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] thr_hi,
   input  logic [WIDTH-1:0] thr_lo,
   output logic [WIDTH-1:0] avg_out,
   output logic             avg_valid,
   output logic             window_full,
   output logic             above_thr,
   output logic [WIDTH-1:0] peak_out
);

   localparam int L  = $clog2(DEPTH);
   localparam int SW = WIDTH + L;   // holds DEPTH*(2^WIDTH-1) without wrap
   localparam logic [L:0] FULL = (L+1)'(DEPTH);

   typedef enum logic {BELOW, ABOVE} cmp_state_t;

   logic [WIDTH-1:0] win_mem [DEPTH];
   logic [L-1:0]     wr_ptr;
   logic [L:0]       count;
   logic [SW-1:0]    sum;
   logic             pend;          // an accept that needs an avg pulse next edge
   logic             accept;
   logic             full_after;
   logic [SW-1:0]    sum_nxt;
   cmp_state_t       state, state_nxt;

   assign accept     = ena & sample_valid & ~clear;
   assign full_after = (count == FULL) || (count == FULL - 1'b1);
   // the replaced entry is part of sum, so this never goes negative
   assign sum_nxt    = sum + SW'(sample_in) - SW'(win_mem[wr_ptr]);

   // window buffer, running sum, fill count and the average output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) win_mem[i] <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         sum       <= '0;
         pend      <= 1'b0;
         avg_out   <= '0;
         avg_valid <= 1'b0;
      end else if (ena) begin
         if (clear) begin
            for (int i = 0; i < DEPTH; i++) win_mem[i] <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            sum       <= '0;
            pend      <= 1'b0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
         end else begin
            if (accept) begin
               win_mem[wr_ptr] <= sample_in;
               sum             <= sum_nxt;
               wr_ptr          <= wr_ptr + L'(1);
               if (count != FULL) count <= count + 1'b1;
               pend            <= full_after;
            end else begin
               pend <= 1'b0;
            end
            // sum here already includes the accept that raised pend
            avg_valid <= pend;
            if (pend) avg_out <= sum[SW-1:L];
         end
      end else begin
         avg_valid <= 1'b0;
      end
   end

   assign window_full = (count == FULL);

   // comparator state register; frozen while the block is disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     state <= BELOW;
      else if (ena)   state <= clear ? BELOW : state_nxt;
   end

   // hysteresis: only the threshold belonging to the current state is tested
   always_comb begin
      state_nxt = state;
      if (avg_valid) begin
         case (state)
            BELOW:   if (avg_out >= thr_hi) state_nxt = ABOVE;
            ABOVE:   if (avg_out <  thr_lo) state_nxt = BELOW;
            default: state_nxt = BELOW;
         endcase
      end
   end

   assign above_thr = (state == ABOVE);

`ifdef ENERGY_PEAK_HOLD_EN
   logic [WIDTH-1:0] peak;

   // peak hold of the published averages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak <= '0;
      end else if (ena) begin
         if (clear)                            peak <= '0;
         else if (avg_valid && avg_out > peak) peak <= avg_out;
      end
   end

   assign peak_out = peak;
`else
   assign peak_out = '0;
`endif

endmodule
